// File: rtl/mxpl_stage.sv
// -----------------------------------------------------------------------------
// mxpl_stage -- layer-1 2x2 stride-2 max-pool engine.
//
// After a start pulse the block walks both layer-0 result maps (kernel 0 then
// kernel 1) through the shared memory port. For every output pixel it issues
// four reads (top-left, top-right, bottom-left, bottom-right of the 2x2
// window), folds the returned samples into a single running-max register and
// writes the result to the matching layer-1 map. No image data is buffered.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   start     in   one-cycle pulse, accepted only while idle
//   busy      out  high from the cycle after start through the last write
//   done      out  one-cycle pulse after the final write
//   crd       out  memory read strobe
//   caddr_rd  out  read address, {2*oy+dy, 2*ox+dx}
//   cdata_rd  in   read data, valid the cycle after the read strobe
//   cwr       out  memory write strobe
//   caddr_wr  out  write address, {oy, ox}
//   cdata_wr  out  write data (running max)
//   csel      out  001/010 read L0 K0/K1, 011/100 write L1 K0/K1, 000 idle
// -----------------------------------------------------------------------------
module mxpl_stage #(
  parameter int DATAW    = 20,
  parameter int ADDRW    = 12,
  parameter int IMG_LOG2 = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             crd,
  output logic [ADDRW-1:0] caddr_rd,
  input  logic [DATAW-1:0] cdata_rd,
  output logic             cwr,
  output logic [ADDRW-1:0] caddr_wr,
  output logic [DATAW-1:0] cdata_wr,
  output logic [2:0]       csel
);

  localparam int OW = IMG_LOG2 - 1;
  localparam logic [OW-1:0] OMAX = '1;

  localparam logic [2:0] CSEL_IDLE  = 3'b000;
  localparam logic [2:0] CSEL_RD_K0 = 3'b001;
  localparam logic [2:0] CSEL_RD_K1 = 3'b010;
  localparam logic [2:0] CSEL_WR_K0 = 3'b011;
  localparam logic [2:0] CSEL_WR_K1 = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_R0   = 3'd1,
    S_R1   = 3'd2,
    S_R2   = 3'd3,
    S_R3   = 3'd4,
    S_LD   = 3'd5,
    S_WR   = 3'd6,
    S_FIN  = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic             ksel_q,  ksel_d;
  logic [OW-1:0]    oy_q,    oy_d;
  logic [OW-1:0]    ox_q,    ox_d;
  logic [DATAW-1:0] mx_q,    mx_d;

  // Unsigned compare; the incoming sample replaces the running max only when
  // it is strictly larger, so ties keep the value already held.
  function automatic logic [DATAW-1:0] max_keep(input logic [DATAW-1:0] cur,
                                                 input logic [DATAW-1:0] cand);
    return (cand > cur) ? cand : cur;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ksel_q  <= 1'b0;
      oy_q    <= '0;
      ox_q    <= '0;
      mx_q    <= '0;
    end else begin
      state_q <= state_d;
      ksel_q  <= ksel_d;
      oy_q    <= oy_d;
      ox_q    <= ox_d;
      mx_q    <= mx_d;
    end
  end

  // Read data lags the strobe by one cycle: the sample requested in R0 lands
  // in R1, R1's in R2, R2's in R3 and R3's in LD.
  always_comb begin
    state_d = state_q;
    ksel_d  = ksel_q;
    oy_d    = oy_q;
    ox_d    = ox_q;
    mx_d    = mx_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_R0;
          ksel_d  = 1'b0;
          oy_d    = '0;
          ox_d    = '0;
        end
      end
      S_R0: state_d = S_R1;
      S_R1: begin
        mx_d    = cdata_rd;
        state_d = S_R2;
      end
      S_R2: begin
        mx_d    = max_keep(mx_q, cdata_rd);
        state_d = S_R3;
      end
      S_R3: begin
        mx_d    = max_keep(mx_q, cdata_rd);
        state_d = S_LD;
      end
      S_LD: begin
        mx_d    = max_keep(mx_q, cdata_rd);
        state_d = S_WR;
      end
      S_WR: begin
        state_d = S_R0;
        if (ox_q != OMAX) begin
          ox_d = ox_q + 1'b1;
        end else begin
          ox_d = '0;
          if (oy_q != OMAX) begin
            oy_d = oy_q + 1'b1;
          end else begin
            oy_d = '0;
            // End of a map: kernel 0 rolls straight into kernel 1.
            if (ksel_q) begin
              state_d = S_FIN;
            end else begin
              ksel_d = 1'b1;
            end
          end
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from registered state only; cdata_rd never reaches
  // an output combinationally.
  logic                  dx, dy;
  logic [2*IMG_LOG2-1:0] rd_idx;
  logic [2*OW-1:0]       wr_idx;

  always_comb begin
    dx     = (state_q == S_R1) || (state_q == S_R3);
    dy     = (state_q == S_R2) || (state_q == S_R3);
    // (2*oy+dy)*2^IMG_LOG2 + (2*ox+dx) is just the bit concatenation.
    rd_idx = {oy_q, dy, ox_q, dx};
    wr_idx = {oy_q, ox_q};
  end

  always_comb begin
    busy     = (state_q != S_IDLE) && (state_q != S_FIN);
    done     = (state_q == S_FIN);
    crd      = (state_q == S_R0) || (state_q == S_R1) ||
               (state_q == S_R2) || (state_q == S_R3);
    cwr      = (state_q == S_WR);
    caddr_rd = ADDRW'(rd_idx);
    caddr_wr = ADDRW'(wr_idx);
    cdata_wr = mx_q;
    if (crd) begin
      csel = ksel_q ? CSEL_RD_K1 : CSEL_RD_K0;
    end else if (cwr) begin
      csel = ksel_q ? CSEL_WR_K1 : CSEL_WR_K0;
    end else begin
      csel = CSEL_IDLE;
    end
  end

endmodule
